video_std_sequencer: RTL



---
 rtl/video_std_sequencer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/video_std_sequencer.sv
// Video standard sequencer: owns the chip model select and the VIC/CPU reset lines.
// Every standard change runs a fixed safe sequence: both resets asserted, the clock-mux
// select flipped, a settle wait, VIC release, a hold wait, then CPU release.
module video_std_sequencer #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [15:0] CFG_TIMEOUT     = 16'd4096,
  parameter logic [15:0] SETTLE_CYCLES   = 16'd2048,
  parameter logic [15:0] CPU_HOLD_CYCLES = 16'd1024
) (
  input  logic       clk_col4x,
  input  logic       rst,
  input  logic       standard_sw,
  input  logic [1:0] chip_cfg,
  input  logic       chip_cfg_valid,
  output logic [1:0] chip,
  output logic       vic_rst,
  output logic       cpu_reset,
  output logic       busy,
  output logic [7:0] switch_count
);

  localparam logic [2:0] S_POR_WAIT = 3'd0;
  localparam logic [2:0] S_IDLE     = 3'd1;
  localparam logic [2:0] S_ASSERT   = 3'd2;
  localparam logic [2:0] S_SWITCH   = 3'd3;
  localparam logic [2:0] S_SETTLE   = 3'd4;
  localparam logic [2:0] S_CPU_HOLD = 3'd5;

  logic        sw_meta, sw_sync;
  logic        sw_db, sw_db_d;
  logic [15:0] db_cnt, db_cnt_d;
  logic        db_hit;
  logic        por_first;
  logic        sw_edge;

  logic [2:0]  state, state_d;
  logic [15:0] cnt, cnt_d;
  logic [15:0] cnt_limit;
  logic        cnt_hit;
  logic        pending, pending_d, pending_base;
  logic        from_switch, from_switch_d;
  logic [1:0]  chip_d;
  logic        vic_rst_d, cpu_reset_d, busy_d;
  logic [7:0]  switch_count_d;

  // Two-flop synchroniser; left unreset so it already tracks the pin when rst drops.
  always_ff @(posedge clk_col4x) begin
    sw_meta <= standard_sw;
    sw_sync <= sw_meta;
  end

  // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing samples.
  assign db_hit = ({1'b0, db_cnt} + 17'd1) >= {1'b0, DEBOUNCE_CYCLES};

  always_comb begin
    sw_db_d  = sw_db;
    db_cnt_d = db_cnt;
    if (por_first) begin
      // First POR_WAIT cycle adopts the current switch level without debouncing.
      sw_db_d  = sw_sync;
      db_cnt_d = '0;
    end else if (sw_sync == sw_db) begin
      db_cnt_d = '0;
    end else if (db_hit) begin
      sw_db_d  = sw_sync;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt + 16'd1;
    end
  end

  // The power-on preload is not a user toggle, so it never produces an edge.
  assign sw_edge = !por_first && (sw_db_d != sw_db);

  // Select the wait length for the shared sequence counter.
  always_comb begin
    cnt_limit = CFG_TIMEOUT;
    case (state)
      S_SETTLE:   cnt_limit = SETTLE_CYCLES;
      S_CPU_HOLD: cnt_limit = CPU_HOLD_CYCLES;
      default:    cnt_limit = CFG_TIMEOUT;
    endcase
  end

  assign cnt_hit = ({1'b0, cnt} + 17'd1) >= {1'b0, cnt_limit};

  // Sequencer next-state and registered output values.
  always_comb begin
    state_d        = state;
    cnt_d          = cnt;
    pending_base   = pending;
    from_switch_d  = from_switch;
    chip_d         = chip;
    vic_rst_d      = vic_rst;
    cpu_reset_d    = cpu_reset;
    switch_count_d = switch_count;
    case (state)
      S_POR_WAIT: begin
        if (chip_cfg_valid) begin
          chip_d        = chip_cfg;
          cnt_d         = '0;
          from_switch_d = 1'b0;
          state_d       = S_SETTLE;
        end else if (cnt_hit) begin
          chip_d        = {1'b0, sw_db};
          cnt_d         = '0;
          from_switch_d = 1'b0;
          state_d       = S_SETTLE;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      S_IDLE: begin
        if (pending) begin
          pending_base = 1'b0;
          vic_rst_d    = 1'b1;
          cpu_reset_d  = 1'b1;
          state_d      = S_ASSERT;
        end
      end
      S_ASSERT: begin
        state_d = S_SWITCH;
      end
      S_SWITCH: begin
        // Both resets are already held here, so the mux select flips safely.
        chip_d        = {chip[1], ~chip[0]};
        from_switch_d = 1'b1;
        cnt_d         = '0;
        state_d       = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_hit) begin
          vic_rst_d = 1'b0;
          cnt_d     = '0;
          state_d   = S_CPU_HOLD;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      S_CPU_HOLD: begin
        if (cnt_hit) begin
          cpu_reset_d   = 1'b0;
          cnt_d         = '0;
          from_switch_d = 1'b0;
          if (from_switch) begin
            switch_count_d = switch_count + 8'd1;
          end
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      default: begin
        state_d = S_POR_WAIT;
        cnt_d   = '0;
      end
    endcase
    // Edges arriving mid-sequence only toggle pending; two of them cancel.
    pending_d = pending_base ^ sw_edge;
    busy_d    = (state_d != S_IDLE);
  end

  // State and output registers; rst forces the safe NTSC/held-reset values at once.
  always_ff @(posedge clk_col4x or posedge rst) begin
    if (rst) begin
      sw_db        <= 1'b0;
      db_cnt       <= '0;
      por_first    <= 1'b1;
      state        <= S_POR_WAIT;
      cnt          <= '0;
      pending      <= 1'b0;
      from_switch  <= 1'b0;
      chip         <= 2'b00;
      vic_rst      <= 1'b1;
      cpu_reset    <= 1'b1;
      busy         <= 1'b1;
      switch_count <= '0;
    end else begin
      sw_db        <= sw_db_d;
      db_cnt       <= db_cnt_d;
      por_first    <= 1'b0;
      state        <= state_d;
      cnt          <= cnt_d;
      pending      <= pending_d;
      from_switch  <= from_switch_d;
      chip         <= chip_d;
      vic_rst      <= vic_rst_d;
      cpu_reset    <= cpu_reset_d;
      busy         <= busy_d;
      switch_count <= switch_count_d;
    end
  end

endmodule
